// File: rtl/digilock_pkg.sv
// Shared constants for the digital lock: time-of-day layout, event IDs
// and log entry sizing.
package digilock_pkg;

  localparam int TS_W = 17;

  // horario = {hours[4:0], minutes[5:0], seconds[5:0]}
  localparam int SS_LSB = 0;
  localparam int MM_LSB = 6;
  localparam int HH_LSB = 12;

  typedef enum logic [1:0] {
    EV_OPEN     = 2'd0,
    EV_WRONG_PW = 2'd1,
    EV_ALARM    = 2'd2,
    EV_ADMIN    = 2'd3
  } ev_id_e;

  function automatic int log_entry_w(int n_ev, int ts_w);
    return $clog2(n_ev) + ts_w;
  endfunction

  function automatic logic [TS_W-1:0] make_horario(logic [4:0] hh, logic [5:0] mm,
                                                   logic [5:0] ss);
    logic [TS_W-1:0] t;
    t = '0;
    t[HH_LSB +: 5] = hh;
    t[MM_LSB +: 6] = mm;
    t[SS_LSB +: 6] = ss;
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the rotating
// pointer, then moves the pointer just past the winner.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int cand;
    cand      = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(rr_ptr) + off) % N;
      if (!gnt_valid && req[IDX_W'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_valid) begin
      if (gnt_idx == IDX_W'(N - 1)) rr_ptr <= '0;
      else                          rr_ptr <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/event_log_arbiter.sv
// Timestamps lock event strobes and funnels them, one per cycle, into a
// shared ring-buffer log that the readout logic drains oldest-first.
module event_log_arbiter
  import digilock_pkg::*;
#(
  parameter  int N_EV    = 4,
  parameter  int DEPTH   = 8,
  parameter  int TS_W    = digilock_pkg::TS_W,
  localparam int ID_W    = $clog2(N_EV),
  localparam int ENTRY_W = log_entry_w(N_EV, TS_W),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [N_EV-1:0]    ev_pulse,
  input  logic [TS_W-1:0]    horario,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               empty,
  output logic               full,
  output logic [CNT_W-1:0]   count,
  output logic [7:0]         lost
);

  localparam int PTR_W = $clog2(DEPTH);

  logic               sync_clr;
  logic [N_EV-1:0]    pending;
  logic [N_EV-1:0]    gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_valid;
  logic [TS_W-1:0]    stamp [N_EV];
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_rd;
  logic               overwrite;
  logic [ENTRY_W-1:0] new_entry;
  int                 loss_now;

  assign sync_clr  = reset | clear;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_rd     = rd_en && !empty;
  assign overwrite = gnt_valid && full && !do_rd;
  assign new_entry = {gnt_idx, stamp[gnt_idx]};

  rr_arbiter #(.N(N_EV)) u_arb (
    .clk       (clk),
    .reset     (sync_clr),
    .req       (pending),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // A pulse on an already-pending source is a loss unless that source is
  // being granted this cycle, in which case the slot is free to re-capture.
  always_comb begin
    loss_now = overwrite ? 1 : 0;
    for (int i = 0; i < N_EV; i++) begin
      if (ev_pulse[i] && pending[i] && !gnt[i]) loss_now = loss_now + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      pending <= '0;
      for (int i = 0; i < N_EV; i++) stamp[i] <= '0;
    end else begin
      for (int i = 0; i < N_EV; i++) begin
        if (ev_pulse[i] && (!pending[i] || gnt[i])) begin
          pending[i] <= 1'b1;
          stamp[i]   <= horario;
        end else if (gnt[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_clr && gnt_valid) mem[wr_ptr] <= new_entry;
  end

  // A simultaneous read and write leaves count alone; a write into a full
  // log with no read pushes the oldest entry out.
  always_ff @(posedge clk) begin
    if (sync_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lost     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (gnt_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (overwrite) rd_ptr <= rd_ptr + 1'b1;
      end
      if (gnt_valid && !do_rd && !full) count <= count + 1'b1;
      else if (!gnt_valid && do_rd)     count <= count - 1'b1;
      if (loss_now != 0) begin
        if (int'(lost) + loss_now > 255) lost <= 8'hFF;
        else                             lost <= 8'(int'(lost) + loss_now);
      end
    end
  end

endmodule

// File: tb/tb_event_log_arbiter.sv
// Directed bench for event_log_arbiter: capture, round-robin order,
// overflow, concurrent read/write, lost accounting and clear.
module tb_event_log_arbiter;
  import digilock_pkg::*;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [3:0]  ev_pulse;
  logic [16:0] horario;
  logic        rd_en;
  logic [18:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic [7:0]  lost;

  int tests;
  int fails;

  event_log_arbiter #(.N_EV(4), .DEPTH(8), .TS_W(17)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .ev_pulse (ev_pulse),
    .horario  (horario),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .lost     (lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [18:0] entryOf(logic [1:0] id, logic [16:0] ts);
    return {id, ts};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are held across one rising edge, then strobes drop; outputs are
  // observed 1 time unit after that edge.
  task automatic applyStimulus(input logic [3:0] ev, input logic [16:0] hor,
                               input logic rd, input logic clr);
    ev_pulse = ev;
    horario  = hor;
    rd_en    = rd;
    clear    = clr;
    @(posedge clk);
    #1;
    ev_pulse = '0;
    rd_en    = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, horario, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(4'b0000, '0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic readExpect(input string tag, input logic [18:0] exp);
    applyStimulus(4'b0000, horario, 1'b1, 1'b0);
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    logic [16:0] h_a, h_b;
    logic [1:0]  id;
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    clear    = 1'b0;
    ev_pulse = '0;
    horario  = '0;
    rd_en    = 1'b0;

    doReset();
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_lost", 32'(lost), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);

    // Single event: pending at the pulse edge, written one edge later.
    h_a = make_horario(5'd13, 6'd7, 6'd42);
    applyStimulus(4'b0010, h_a, 1'b0, 1'b0);
    checkOutput("single_cnt_pend", 32'(count), 32'd0);
    idle(1);
    checkOutput("single_cnt_wr", 32'(count), 32'd1);
    readExpect("single_rd", entryOf(EV_WRONG_PW, h_a));
    checkOutput("single_empty", 32'(empty), 32'd1);
    idle(1);
    checkOutput("single_valid_drop", 32'(rd_valid), 32'd0);
    checkOutput("single_data_hold", 32'(rd_data), 32'(entryOf(EV_WRONG_PW, h_a)));

    // All four sources at once, rr pointer at 0.
    doReset();
    h_a = make_horario(5'd8, 6'd30, 6'd0);
    applyStimulus(4'b1111, h_a, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      checkOutput($sformatf("rr0_cnt%0d", k), 32'(count), 32'(k));
    end
    for (int k = 0; k < 4; k++) begin
      id = 2'(k);
      readExpect($sformatf("rr0_rd%0d", k), entryOf(id, h_a));
    end

    // Move the pointer to 2 via a lone grant to source 1, then repeat.
    applyStimulus(4'b0010, h_a, 1'b0, 1'b0);
    idle(1);
    readExpect("rr2_seed", entryOf(EV_WRONG_PW, h_a));
    h_b = make_horario(5'd9, 6'd0, 6'd1);
    applyStimulus(4'b1111, h_b, 1'b0, 1'b0);
    idle(4);
    checkOutput("rr2_cnt", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      id = 2'((k + 2) % 4);
      readExpect($sformatf("rr2_rd%0d", k), entryOf(id, h_b));
    end

    // Ten events into an eight-entry log: two oldest overwritten.
    doReset();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(4'b0001, 17'(k), 1'b0, 1'b0);
      idle(1);
    end
    checkOutput("ovf_count", 32'(count), 32'd8);
    checkOutput("ovf_full", 32'(full), 32'd1);
    checkOutput("ovf_lost", 32'(lost), 32'd2);
    for (int k = 3; k <= 10; k++) readExpect($sformatf("ovf_rd%0d", k), entryOf(EV_OPEN, 17'(k)));
    checkOutput("ovf_empty", 32'(empty), 32'd1);

    // Full log with a read and a write on the same edge.
    doReset();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(4'b0001, 17'(k), 1'b0, 1'b0);
      idle(1);
    end
    checkOutput("rw_full_pre", 32'(full), 32'd1);
    applyStimulus(4'b0001, 17'd9, 1'b0, 1'b0);
    applyStimulus(4'b0000, horario, 1'b1, 1'b0);
    checkOutput("rw_valid", 32'(rd_valid), 32'd1);
    checkOutput("rw_data", 32'(rd_data), 32'(entryOf(EV_OPEN, 17'd1)));
    checkOutput("rw_count", 32'(count), 32'd8);
    checkOutput("rw_lost", 32'(lost), 32'd0);
    for (int k = 2; k <= 9; k++) readExpect($sformatf("rw_rd%0d", k), entryOf(EV_OPEN, 17'(k)));

    // Repeat pulse on pending source 2 while source 0 wins: lost, old stamp kept.
    doReset();
    h_a = make_horario(5'd1, 6'd2, 6'd3);
    h_b = make_horario(5'd4, 6'd5, 6'd6);
    applyStimulus(4'b0101, h_a, 1'b0, 1'b0);
    applyStimulus(4'b0100, h_b, 1'b0, 1'b0);
    checkOutput("coll_lost", 32'(lost), 32'd1);
    checkOutput("coll_cnt1", 32'(count), 32'd1);
    idle(1);
    checkOutput("coll_cnt2", 32'(count), 32'd2);
    readExpect("coll_rd0", entryOf(EV_OPEN, h_a));
    readExpect("coll_rd1", entryOf(EV_ALARM, h_a));

    // Repeat pulse on source 2 in its own grant cycle: re-captured, no loss.
    doReset();
    h_a = make_horario(5'd7, 6'd8, 6'd9);
    h_b = make_horario(5'd10, 6'd11, 6'd12);
    applyStimulus(4'b0100, h_a, 1'b0, 1'b0);
    applyStimulus(4'b0100, h_b, 1'b0, 1'b0);
    checkOutput("recap_lost1", 32'(lost), 32'd0);
    idle(1);
    checkOutput("recap_cnt", 32'(count), 32'd2);
    checkOutput("recap_lost2", 32'(lost), 32'd0);
    readExpect("recap_rd0", entryOf(EV_ALARM, h_a));
    readExpect("recap_rd1", entryOf(EV_ALARM, h_b));

    // Clear mid-stream with pending events, stored entries and a nonzero lost.
    doReset();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(4'b0001, 17'(k), 1'b0, 1'b0);
      idle(1);
    end
    checkOutput("clr_cnt5", 32'(count), 32'd5);
    applyStimulus(4'b1110, 17'h1AAAA, 1'b0, 1'b0);
    applyStimulus(4'b0100, 17'h05555, 1'b0, 1'b0);
    checkOutput("clr_pre_cnt", 32'(count), 32'd6);
    checkOutput("clr_pre_lost", 32'(lost), 32'd1);
    applyStimulus(4'b1111, 17'h00777, 1'b1, 1'b1);
    checkOutput("clr_count", 32'(count), 32'd0);
    checkOutput("clr_empty", 32'(empty), 32'd1);
    checkOutput("clr_full", 32'(full), 32'd0);
    checkOutput("clr_lost", 32'(lost), 32'd0);
    checkOutput("clr_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("clr_rd_data", 32'(rd_data), 32'd0);
    idle(3);
    checkOutput("clr_no_writes", 32'(count), 32'd0);
    applyStimulus(4'b0000, horario, 1'b1, 1'b0);
    checkOutput("empty_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("empty_rd_data", 32'(rd_data), 32'd0);
    checkOutput("empty_rd_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_log_arbiter.md
Name: event_log_arbiter

Overview:
Timestamps lock events, such as door open, wrong password, alarm and admin access, against the running time-of-day word horario. That word is 17 bits: {hours[4:0], minutes[5:0], seconds[5:0]}.
Several event sources compete for one shared log ring buffer. A round-robin arbiter writes at most one entry per cycle.
Sits between the lock FSM event strobes, the clock counter output and the display/readout logic.

Parameters:
N_EV, 4, number of event sources; event ID = source index
DEPTH, 8, log entries; power of 2, >= 2
TS_W, 17, timestamp width; must match horario

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous log clear, active-high
ev_pulse  in  N_EV  one-cycle event strobes, one bit per source
horario  in  TS_W  current time {hh,mm,ss}, stable in clk domain
rd_en  in  1  pop oldest entry
rd_data  out  ID_W+TS_W  {ev_id, timestamp}; ID_W = clog2(N_EV)
rd_valid  out  1  rd_data valid (one-cycle pulse)
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  clog2(DEPTH)+1  entries stored
lost  out  8  saturating count of dropped/overwritten events

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset, and clear with identical effect:
  - pending = 0, stamp regs = 0, rr pointer = 0, wr_ptr = rd_ptr = 0.
  - Outputs: count = 0, lost = 0, rd_data = 0, rd_valid = 0, empty = 1, full = 0.
  - ev_pulse in the same cycle as reset/clear is dropped and not counted in lost.
- Capture, per source i:
  - ev_pulse[i] with pending[i] = 0: pending[i] <= 1 and stamp[i] <= horario, sampled that same edge.
  - ev_pulse[i] with pending[i] = 1 and i not granted this cycle: the original stamp is kept and lost is incremented.
  - ev_pulse[i] in the cycle i is granted: the pulse is re-captured as a new pending entry with the new stamp. No loss.
- Arbitration:
  - Each cycle, grant the first pending source searching from rr_ptr upward, mod N_EV.
  - On a grant of i: rr_ptr <= (i+1) mod N_EV, pending[i] cleared, entry {i, stamp[i]} written at mem[wr_ptr].
  - With no pending source, rr_ptr holds.
  - Pulse at edge t becomes pending at t; earliest write is at edge t+1; count reflects it after edge t+1.
- Ring buffer:
  - Pointers wrap mod DEPTH.
  - Write only: wr_ptr++ and count++.
  - Write while full with no read: overwrite the oldest entry. wr_ptr++, rd_ptr++, count stays DEPTH, lost++.
  - rd_en with empty = 0: rd_data <= mem[rd_ptr] and rd_valid <= 1 next cycle, rd_ptr++, count--.
  - rd_en while empty: ignored. rd_valid stays 0, rd_data holds.
  - Write and read in the same cycle: the read returns the pre-write oldest entry, count is unchanged, no loss. Applies also when full.
- lost saturates at 255; in one cycle it increments by at most 1 per loss event; multiple losses in one cycle add their total, clamped.
- rd_data holds its last value when rd_valid = 0.
- horario is treated as opaque. No range checks, and wrap 23:59:59 -> 0 needs no special handling.

Decomposition:
- Package digilock_pkg holds:
  - TS_W = 17.
  - HH/MM/SS field offsets: SS [5:0], MM [11:6], HH [16:12].
  - Event IDs: EV_OPEN = 0, EV_WRONG_PW = 1, EV_ALARM = 2, EV_ADMIN = 3.
  - Log entry width function.
- One sub-module, rr_arbiter, parameterised by N: request vector in, one-hot grant and index out, rotating pointer inside.
- The ring buffer stays inline.

Test Plan:
- Reset, then ev_pulse = 4'b0010 with horario = {5'd13, 6'd7, 6'd42}, then rd_en -> count = 1 two cycles after the pulse, then rd_data = {2'd1, 13:07:42} with rd_valid = 1, then empty = 1.
- ev_pulse = 4'b1111 in one cycle, rr_ptr = 0 -> entries written over 4 consecutive cycles in ID order 0, 1, 2, 3. A repeat 4'b1111 after rr_ptr = 2 gives order 2, 3, 0, 1.
- 10 single pulses from source 0, DEPTH = 8, no reads -> count = 8, full = 1, lost = 2. Readout yields the 3rd through 10th events in order.
- Full buffer with rd_en and a new write in the same cycle -> rd_data = oldest entry, count stays 8, lost unchanged.
- Second ev_pulse[2] while pending[2] = 1 and source 0 is granted -> lost = 1 and the entry keeps the first timestamp. A pulse on source 2 in its own grant cycle -> two entries, lost = 0.
- clear asserted mid-stream with pending events and count = 5 -> next cycle count = 0, empty = 1, lost = 0, no further writes. rd_en while empty -> rd_valid stays 0.
